ringosc_freq_meter: RTL
=======================

RINGOSC_FREQ_METER -- requirements
Module: ringosc_freq_meter

Interface
REQ-001 Parameter N_OSC, default 4: number of ring oscillators under control, range 1..16.
REQ-002 Parameter SEL_WIDTH, default 2: width of osc_sel, at least clog2(N_OSC), minimum 1.
REQ-003 Parameter SETTLE_CYCLES, default 16: clk cycles an oscillator runs before counting starts, range 3..65535.
REQ-004 Parameter WINDOW_CYCLES, default 1024: clk cycles of the counting gate window, range 1..2^24.
REQ-005 Parameter COUNT_WIDTH, default 16: width of the edge counter and result.
REQ-006 clk  input  1  single system clock; all state changes on its rising edge.
REQ-007 rst  input  1  reset; synchronous, active-high.
REQ-008 osc_in  input  N_OSC  raw oscillator outputs, asynchronous to clk; the instantiator pre-divides each below clk/4.
REQ-009 osc_enable  output  N_OSC  per-oscillator run enable; one-hot or all-zero.
REQ-010 start  input  1  measurement request, sampled only in IDLE.
REQ-011 osc_sel  input  SEL_WIDTH  oscillator index to measure, captured with start.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 result  output  COUNT_WIDTH  rising-edge count of the last measurement.
REQ-014 result_osc  output  SEL_WIDTH  index that produced result.
REQ-015 result_overflow  output  1  high if the counter saturated during the window.
REQ-016 result_valid  output  1  result fields valid; held until accepted.
REQ-017 result_ready  input  1  consumer accepts the result when high with result_valid.

Function
REQ-018 The FSM SHALL have exactly four states: IDLE, SETTLE, MEASURE, DONE.
REQ-019 In IDLE, start=1 with osc_sel<N_OSC: capture osc_sel, load the cycle timer, go to SETTLE next cycle.
REQ-020 In IDLE, start=1 with osc_sel>=N_OSC: stay in IDLE, drive no enable, produce no result.
REQ-021 start in SETTLE, MEASURE or DONE: ignored, not queued.
REQ-022 osc_enable[sel]=1 in SETTLE and MEASURE; all other bits 0; all bits 0 in IDLE and DONE.
REQ-023 Only osc_in[sel] SHALL pass through a two-flop synchronizer; a third flop SHALL detect rising edges.
REQ-024 SETTLE lasts exactly SETTLE_CYCLES cycles, then MEASURE; the edge counter clears on MEASURE entry.
REQ-025 MEASURE lasts exactly WINDOW_CYCLES cycles; each synchronized rising edge detected in the window increments the counter by 1.
REQ-026 The counter SHALL saturate at 2^COUNT_WIDTH-1 and set a sticky overflow flag for that measurement; it never wraps.
REQ-027 After the final MEASURE cycle, go to DONE; result, result_osc and result_overflow latch on DONE entry.
REQ-028 Latency: start accepted in cycle t, result_valid first high in cycle t+1+SETTLE_CYCLES+WINDOW_CYCLES.
REQ-029 In DONE, result_valid=1 and all result fields stay stable until result_valid and result_ready are both high in one cycle.
REQ-030 On handshake, go to IDLE next cycle with result_valid=0; start is acceptable in that IDLE cycle.
REQ-031 result_ready while result_valid=0 has no effect.
REQ-032 Result fields keep their last values in IDLE; they change only on DONE entry.

Reset
REQ-033 rst=1 at a clk edge forces IDLE in every state, including mid-SETTLE or mid-MEASURE.
REQ-034 After reset: osc_enable=0, busy=0, result_valid=0, result=0, result_osc=0, result_overflow=0.
REQ-035 After reset, synchronizer flops, the counter and the timer are cleared; no partial measurement survives.

Verification
REQ-036 Defaults, osc_sel=2, osc_in[2] with period 8 clk -> osc_enable=4'b0100 for 1040 cycles; result=128 ±1, result_osc=2, overflow=0; valid at t+1041.
REQ-037 COUNT_WIDTH=4, period 4 clk, WINDOW=1024 -> result=15, result_overflow=1.
REQ-038 start with osc_sel=5, N_OSC=4 -> busy stays 0, osc_enable stays 0, no result_valid.
REQ-039 result_ready held low 50 cycles in DONE, start pulsed meanwhile -> fields stable, start ignored; ready=1 -> IDLE next cycle.
REQ-040 rst asserted at window cycle 500 -> next cycle: osc_enable=0, busy=0, result_valid=0; new start gives a full-window result.
REQ-041 osc_in held at constant 1 -> result=0, result_overflow=0.

Source files
------------

// File: rtl/ringosc_freq_meter.sv
// rtl/ringosc_freq_meter.sv - ring oscillator frequency meter: settle, gated edge count, held result
// One oscillator at a time is enabled, synchronized, and its rising edges are counted over a fixed clk window.
module ringosc_freq_meter #(
    parameter int N_OSC         = 4,
    parameter int SEL_WIDTH     = 2,
    parameter int SETTLE_CYCLES = 16,
    parameter int WINDOW_CYCLES = 1024,
    parameter int COUNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_OSC-1:0]       osc_in,
    output logic [N_OSC-1:0]       osc_enable,
    input  logic                   start,
    input  logic [SEL_WIDTH-1:0]   osc_sel,
    output logic                   busy,
    output logic [COUNT_WIDTH-1:0] result,
    output logic [SEL_WIDTH-1:0]   result_osc,
    output logic                   result_overflow,
    output logic                   result_valid,
    input  logic                   result_ready
);

    localparam int TW = 24;
    localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] WINDOW_LOAD = TW'(WINDOW_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_MEASURE, S_DONE} state_t;

    state_t                 r_state;
    logic [TW-1:0]          r_timer;
    logic [SEL_WIDTH-1:0]   r_sel;
    logic [N_OSC-1:0]       r_osc_en;
    logic                   r_busy;
    logic                   r_sync1, r_sync2, r_sync3;
    logic [COUNT_WIDTH-1:0] r_cnt;
    logic                   r_ovf;
    logic [COUNT_WIDTH-1:0] r_result;
    logic [SEL_WIDTH-1:0]   r_result_osc;
    logic                   r_result_ovf;
    logic                   r_valid;

    logic                   w_osc_bit;
    logic [N_OSC-1:0]       w_onehot;
    logic                   w_sel_ok;
    logic                   w_edge;
    logic [COUNT_WIDTH-1:0] w_cnt_next;
    logic                   w_ovf_next;

    // Selection by compare loop keeps index widths legal when SEL_WIDTH exceeds clog2(N_OSC).
    always_comb begin
        w_osc_bit = 1'b0;
        w_onehot  = '0;
        for (int i = 0; i < N_OSC; i++) begin
            if (r_sel == SEL_WIDTH'(i))
                w_osc_bit = osc_in[i];
            w_onehot[i] = (osc_sel == SEL_WIDTH'(i));
        end
        w_sel_ok = (int'(osc_sel) < N_OSC);
    end

    assign w_edge = r_sync2 & ~r_sync3;

    always_comb begin
        w_cnt_next = r_cnt;
        w_ovf_next = r_ovf;
        if (w_edge) begin
            if (&r_cnt)
                w_ovf_next = 1'b1;
            else
                w_cnt_next = r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_timer      <= '0;
            r_sel        <= '0;
            r_osc_en     <= '0;
            r_busy       <= 1'b0;
            r_sync1      <= 1'b0;
            r_sync2      <= 1'b0;
            r_sync3      <= 1'b0;
            r_cnt        <= '0;
            r_ovf        <= 1'b0;
            r_result     <= '0;
            r_result_osc <= '0;
            r_result_ovf <= 1'b0;
            r_valid      <= 1'b0;
        end else begin
            r_sync1 <= w_osc_bit;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            case (r_state)
                S_IDLE: begin
                    if (start && w_sel_ok) begin
                        r_sel    <= osc_sel;
                        r_timer  <= SETTLE_LOAD;
                        r_osc_en <= w_onehot;
                        r_busy   <= 1'b1;
                        r_state  <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (r_timer == '0) begin
                        r_timer <= WINDOW_LOAD;
                        r_cnt   <= '0;
                        r_ovf   <= 1'b0;
                        r_state <= S_MEASURE;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                S_MEASURE: begin
                    r_cnt <= w_cnt_next;
                    r_ovf <= w_ovf_next;
                    // The final window cycle's edge is folded into the latched result.
                    if (r_timer == '0) begin
                        r_osc_en     <= '0;
                        r_result     <= w_cnt_next;
                        r_result_osc <= r_sel;
                        r_result_ovf <= w_ovf_next;
                        r_valid      <= 1'b1;
                        r_state      <= S_DONE;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                S_DONE: begin
                    if (r_valid && result_ready) begin
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign osc_enable      = r_osc_en;
    assign busy            = r_busy;
    assign result          = r_result;
    assign result_osc      = r_result_osc;
    assign result_overflow = r_result_ovf;
    assign result_valid    = r_valid;

endmodule
